// File: rtl/vga_timing_gen.sv
// SVGA raster timing source: pixel-enable divider, h/v counters with phase FSMs,
// syncs, active flag and centred coordinates. VGA_TIMING_FRAME_CNT_EN adds frame_cnt.
module vga_timing_gen #(
  parameter int   DIV      = 3,
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 40,
  parameter int   H_SYNC   = 128,
  parameter int   H_BP     = 88,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 23,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               pix_en,
  output logic [11:0]        hcount,
  output logic [11:0]        vcount,
  output logic               active,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic signed [11:0] x_c,
  output logic signed [11:0] y_c,
  output logic [15:0]        frame_cnt
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;

  // Last position of each phase; the FSM leaves the phase on the tick that consumes it.
  localparam logic [11:0] H_END_ACT = 12'(H_ACTIVE - 1);
  localparam logic [11:0] H_END_FP  = 12'(H_ACTIVE + H_FP - 1);
  localparam logic [11:0] H_END_SYN = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] H_LAST    = 12'(H_TOT - 1);
  localparam logic [11:0] V_END_ACT = 12'(V_ACTIVE - 1);
  localparam logic [11:0] V_END_FP  = 12'(V_ACTIVE + V_FP - 1);
  localparam logic [11:0] V_END_SYN = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [11:0] V_LAST    = 12'(V_TOT - 1);
  localparam logic [11:0] X_OFF     = 12'(H_ACTIVE / 2);
  localparam logic [11:0] Y_OFF     = 12'(V_ACTIVE / 2);

  typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYN, PH_BP} phase_t;

  logic [DW-1:0] div;
  logic [11:0]   h, v;
  phase_t        hst, vst;
  logic          tick, h_wrap, v_wrap;

  assign tick   = (div == DW'(DIV - 1));
  assign h_wrap = (h == H_LAST);
  assign v_wrap = (v == V_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  div <= '0;
    else if (tick) div <= '0;
    else           div <= div + DW'(1);
  end

  // Outputs are registered from the pre-advance (h,v) and FSM states, so every
  // output field describes the same pixel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h           <= '0;
      v           <= '0;
      hst         <= PH_ACT;
      vst         <= PH_ACT;
      pix_en      <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      active      <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      x_c         <= '0;
      y_c         <= '0;
    end else begin
      pix_en <= tick;
      if (tick) begin
        hcount      <= h;
        vcount      <= v;
        active      <= (hst == PH_ACT) && (vst == PH_ACT);
        hsync       <= (hst == PH_SYN) ? SYNC_POL : ~SYNC_POL;
        vsync       <= (vst == PH_SYN) ? SYNC_POL : ~SYNC_POL;
        line_start  <= (h == '0);
        frame_start <= (h == '0) && (v == '0);
        x_c         <= h - X_OFF;
        y_c         <= v - Y_OFF;

        h <= h_wrap ? '0 : h + 12'd1;
        case (hst)
          PH_ACT:  if (h == H_END_ACT) hst <= PH_FP;
          PH_FP:   if (h == H_END_FP)  hst <= PH_SYN;
          PH_SYN:  if (h == H_END_SYN) hst <= PH_BP;
          PH_BP:   if (h_wrap)         hst <= PH_ACT;
          default: hst <= PH_ACT;
        endcase

        if (h_wrap) begin
          v <= v_wrap ? '0 : v + 12'd1;
          case (vst)
            PH_ACT:  if (v == V_END_ACT) vst <= PH_FP;
            PH_FP:   if (v == V_END_FP)  vst <= PH_SYN;
            PH_SYN:  if (v == V_END_SYN) vst <= PH_BP;
            PH_BP:   if (v_wrap)         vst <= PH_ACT;
            default: vst <= PH_ACT;
          endcase
        end
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // The frame start right after reset is not a completed frame, so it only arms the counter.
  logic fc_armed;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fc_armed  <= 1'b0;
      frame_cnt <= '0;
    end else if (tick && (h == '0) && (v == '0)) begin
      fc_armed <= 1'b1;
      if (fc_armed) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a full-size SVGA instance (DIV=3, active-low syncs) and a
// shrunken-raster instance (DIV=1, active-high syncs) for frame-level behaviour.
module tb_vga_timing_gen;

  localparam int F =
`ifdef VGA_TIMING_FRAME_CNT_EN
    1;
`else
    0;
`endif

  typedef struct {
    int idx; int h; int v;
    bit hs; bit vs; bit act; bit ls; bit fs;
    int x; int y; int fc;
  } exp_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0, rst_s_n = 1'b0;
  always #5 clock = ~clock;

  logic        pix_en, active, hsync, vsync, line_start, frame_start;
  logic [11:0] hcount, vcount, x_c, y_c;
  logic [15:0] frame_cnt;
  logic        pix_en_s, active_s, hsync_s, vsync_s, line_start_s, frame_start_s;
  logic [11:0] hcount_s, vcount_s, x_c_s, y_c_s;
  logic [15:0] frame_cnt_s;

  vga_timing_gen dut (
    .clock(clock), .reset_n(rst_n), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
    .active(active), .hsync(hsync), .vsync(vsync), .line_start(line_start),
    .frame_start(frame_start), .x_c(x_c), .y_c(y_c), .frame_cnt(frame_cnt));

  // 16x12 raster: hsync on h 10..12, vsync on v 7..8, frame = 192 ticks.
  vga_timing_gen #(.DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)) dut_s (
    .clock(clock), .reset_n(rst_s_n), .pix_en(pix_en_s), .hcount(hcount_s), .vcount(vcount_s),
    .active(active_s), .hsync(hsync_s), .vsync(vsync_s), .line_start(line_start_s),
    .frame_start(frame_start_s), .x_c(x_c_s), .y_c(y_c_s), .frame_cnt(frame_cnt_s));

  int checks = 0, failures = 0;
  int b_idx = -1, s_idx = -1;
  int hslow = 0, lscnt = 0, s_lows = 0;
  bit s_seen = 0;
  exp_t qb[$], qs[$];

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, a, e);
    end
  endtask

  function automatic exp_t mk(int idx, int h, int v, bit hs, bit vs, bit act, bit ls, bit fs,
                              int x, int y, int fc);
    exp_t e;
    e.idx = idx; e.h = h; e.v = v; e.hs = hs; e.vs = vs; e.act = act;
    e.ls = ls; e.fs = fs; e.x = x; e.y = y; e.fc = fc;
    return e;
  endfunction

  task automatic chk_entry(input string tag, input exp_t e, input logic [11:0] hc, input logic [11:0] vc,
                           input logic hs, input logic vs, input logic act, input logic ls,
                           input logic fs, input logic [11:0] x, input logic [11:0] y,
                           input logic [15:0] fc);
    string p;
    p = $sformatf("%s[%0d]", tag, e.idx);
    cmp({p, ".hcount"}, 32'(hc), 32'(e.h));
    cmp({p, ".vcount"}, 32'(vc), 32'(e.v));
    cmp({p, ".hsync"}, 32'(hs), 32'(e.hs));
    cmp({p, ".vsync"}, 32'(vs), 32'(e.vs));
    cmp({p, ".active"}, 32'(act), 32'(e.act));
    cmp({p, ".line_start"}, 32'(ls), 32'(e.ls));
    cmp({p, ".frame_start"}, 32'(fs), 32'(e.fs));
    cmp({p, ".x_c"}, {20'd0, x}, {20'd0, 12'(e.x)});
    cmp({p, ".y_c"}, {20'd0, y}, {20'd0, 12'(e.y)});
    cmp({p, ".frame_cnt"}, 32'(fc), 32'(e.fc));
  endtask

  // Monitor for the full-size instance: tick index counts pix_en strobes since reset.
  initial forever begin
    @(negedge clock);
    if (!rst_n) b_idx = -1;
    else if (pix_en) begin
      b_idx++;
      if (b_idx <= 1055 && !hsync) hslow++;
      if (b_idx >= 1 && b_idx <= 1055 && line_start) lscnt++;
      while (qb.size() > 0 && qb[0].idx < b_idx) begin
        cmp($sformatf("big_missed[%0d]", qb[0].idx), 32'(b_idx), 32'(qb[0].idx));
        void'(qb.pop_front());
      end
      if (qb.size() > 0 && qb[0].idx == b_idx) begin
        chk_entry("big", qb[0], hcount, vcount, hsync, vsync, active, line_start,
                  frame_start, x_c, y_c, frame_cnt);
        void'(qb.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (!rst_s_n) begin s_idx = -1; s_seen = 0; end
    else begin
      if (s_seen && !pix_en_s) s_lows++;
      if (pix_en_s) begin
        s_seen = 1;
        s_idx++;
        while (qs.size() > 0 && qs[0].idx < s_idx) begin
          cmp($sformatf("small_missed[%0d]", qs[0].idx), 32'(s_idx), 32'(qs[0].idx));
          void'(qs.pop_front());
        end
        if (qs.size() > 0 && qs[0].idx == s_idx) begin
          chk_entry("small", qs[0], hcount_s, vcount_s, hsync_s, vsync_s, active_s,
                    line_start_s, frame_start_s, x_c_s, y_c_s, frame_cnt_s);
          void'(qs.pop_front());
        end
      end
    end
  end

  initial begin
    bit got;
    repeat (4) @(negedge clock);
    cmp("rst.pix_en", 32'(pix_en), 0);
    cmp("rst.hcount", 32'(hcount), 0);
    cmp("rst.vcount", 32'(vcount), 0);
    cmp("rst.hsync", 32'(hsync), 1);
    cmp("rst.vsync", 32'(vsync), 1);
    cmp("rst.active", 32'(active), 0);
    cmp("rst.line_start", 32'(line_start), 0);
    cmp("rst.frame_start", 32'(frame_start), 0);
    cmp("rst.x_c", 32'(x_c), 0);
    cmp("rst.y_c", 32'(y_c), 0);
    cmp("rst.frame_cnt", 32'(frame_cnt), 0);
    cmp("rst_s.hsync", 32'(hsync_s), 0);
    cmp("rst_s.vsync", 32'(vsync_s), 0);

    qb.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1, -400, -300, 0));
    qb.push_back(mk(799, 799, 0, 1, 1, 1, 0, 0, 399, -300, 0));
    qb.push_back(mk(800, 800, 0, 1, 1, 0, 0, 0, 400, -300, 0));
    qb.push_back(mk(839, 839, 0, 1, 1, 0, 0, 0, 439, -300, 0));
    qb.push_back(mk(840, 840, 0, 0, 1, 0, 0, 0, 440, -300, 0));
    qb.push_back(mk(967, 967, 0, 0, 1, 0, 0, 0, 567, -300, 0));
    qb.push_back(mk(968, 968, 0, 1, 1, 0, 0, 0, 568, -300, 0));
    qb.push_back(mk(1055, 1055, 0, 1, 1, 0, 0, 0, 655, -300, 0));
    qb.push_back(mk(1056, 0, 1, 1, 1, 1, 1, 0, -400, -299, 0));
    qb.push_back(mk(1956, 900, 1, 0, 1, 0, 0, 0, 500, -299, 0));

    qs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, -4, -3, 0));
    qs.push_back(mk(7, 7, 0, 0, 0, 1, 0, 0, 3, -3, 0));
    qs.push_back(mk(8, 8, 0, 0, 0, 0, 0, 0, 4, -3, 0));
    qs.push_back(mk(9, 9, 0, 0, 0, 0, 0, 0, 5, -3, 0));
    qs.push_back(mk(10, 10, 0, 1, 0, 0, 0, 0, 6, -3, 0));
    qs.push_back(mk(12, 12, 0, 1, 0, 0, 0, 0, 8, -3, 0));
    qs.push_back(mk(13, 13, 0, 0, 0, 0, 0, 0, 9, -3, 0));
    qs.push_back(mk(15, 15, 0, 0, 0, 0, 0, 0, 11, -3, 0));
    qs.push_back(mk(16, 0, 1, 0, 0, 1, 1, 0, -4, -2, 0));
    qs.push_back(mk(96, 0, 6, 0, 0, 0, 1, 0, -4, 3, 0));
    qs.push_back(mk(111, 15, 6, 0, 0, 0, 0, 0, 11, 3, 0));
    qs.push_back(mk(112, 0, 7, 0, 1, 0, 1, 0, -4, 4, 0));
    qs.push_back(mk(143, 15, 8, 0, 1, 0, 0, 0, 11, 5, 0));
    qs.push_back(mk(144, 0, 9, 0, 0, 0, 1, 0, -4, 6, 0));
    qs.push_back(mk(191, 15, 11, 0, 0, 0, 0, 0, 11, 8, 0));
    qs.push_back(mk(192, 0, 0, 0, 0, 1, 1, 1, -4, -3, F * 1));
    qs.push_back(mk(384, 0, 0, 0, 0, 1, 1, 1, -4, -3, F * 2));
    qs.push_back(mk(576, 0, 0, 0, 0, 1, 1, 1, -4, -3, F * 3));
    qs.push_back(mk(699, 11, 7, 1, 1, 0, 0, 0, 7, 4, F * 3));

    rst_n = 1'b1; rst_s_n = 1'b1;
    @(negedge clock); cmp("pix_en.edge1", 32'(pix_en), 0);
    @(negedge clock); cmp("pix_en.edge2", 32'(pix_en), 0);
    @(negedge clock); cmp("pix_en.edge3", 32'(pix_en), 1);
    @(negedge clock); cmp("pix_en.edge4", 32'(pix_en), 0);

    // Small instance: reset in the middle of a vsync/hsync pulse of the fourth frame.
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clock); #1;
      if (s_idx == 699) got = 1;
    end
    cmp("wait_small_699", 32'(got), 1);
    rst_s_n = 1'b0;
    #1;
    cmp("small_async.hsync", 32'(hsync_s), 0);
    cmp("small_async.vsync", 32'(vsync_s), 0);
    cmp("small_async.hcount", 32'(hcount_s), 0);
    cmp("small_async.frame_cnt", 32'(frame_cnt_s), 0);
    cmp("small.pix_en_gaps", 32'(s_lows), 0);
    qs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, -4, -3, 0));
    @(negedge clock); @(negedge clock);
    rst_s_n = 1'b1;

    got = 0;
    for (int i = 0; i < 8000 && !got; i++) begin
      @(negedge clock); #1;
      if (b_idx == 1956) got = 1;
    end
    cmp("wait_big_1956", 32'(got), 1);
    cmp("line0.hsync_low_ticks", 32'(hslow), 128);
    cmp("line0.extra_line_start", 32'(lscnt), 0);
    rst_n = 1'b0;
    #1;
    cmp("big_async.hsync", 32'(hsync), 1);
    cmp("big_async.vsync", 32'(vsync), 1);
    cmp("big_async.hcount", 32'(hcount), 0);
    cmp("big_async.vcount", 32'(vcount), 0);
    cmp("big_async.active", 32'(active), 0);
    qb.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1, -400, -300, 0));
    @(negedge clock); @(negedge clock);
    rst_n = 1'b1;
    repeat (12) @(negedge clock);

    cmp("big.queue_left", 32'(qb.size()), 0);
    cmp("small.queue_left", 32'(qs.size()), 0);
    cmp("small.pix_en_gaps_after", 32'(s_lows), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Upstream timing stage for the shader pipeline. Divides the system clock into a pixel-enable strobe and generates the 800×600 SVGA raster counters, sync pulses, active-video flag and centred signed coordinates that the shader stage consumes. The block is the single source of raster timing in the design, so shader layers never keep their own counters.

## Interface
- DIV, 3: system clocks per pixel (≥1).
- H_ACTIVE, 800 / H_FP, 40 / H_SYNC, 128 / H_BP, 88: horizontal phase lengths in pixels (total 1056).
- V_ACTIVE, 600 / V_FP, 1 / V_SYNC, 4 / V_BP, 23: vertical phase lengths in lines (total 628).
- SYNC_POL, 0: asserted level of hsync/vsync; 0 means active-low.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- pix_en  out  1  one-clock strobe; outputs changed on the previous edge.
- hcount  out  12  pixel column, 0..1055.
- vcount  out  12  line, 0..627.
- active  out  1  high when hcount<H_ACTIVE and vcount<V_ACTIVE.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- line_start  out  1  high while hcount==0.
- frame_start  out  1  high while hcount==0 and vcount==0.
- x_c  out  12 signed  hcount − H_ACTIVE/2.
- y_c  out  12 signed  vcount − V_ACTIVE/2.
- frame_cnt  out  16  completed-frame counter (see Configuration).

## Operation
- Divider: div counts 0..DIV−1 and wraps. A tick occurs on the edge where div==DIV−1. With DIV=1, every edge is a tick.
- Internal position (h,v) resets to (0,0). On each tick:
  - All raster outputs are registered from the current (h,v).
  - h then advances. At h==1055, h wraps to 0 and v advances. At v==627, v wraps to 0.
- Horizontal phase FSM: H_ACT → H_FP → H_SYN → H_BP → H_ACT. Transitions occur at the phase boundaries, i.e. h = 800, 840, 968 and 0.
- Vertical phase FSM: V_ACT → V_FP → V_SYN → V_BP → V_ACT. Transitions occur at line boundaries v = 600, 601, 605 and 0, on the tick where h wraps.
- Sync outputs:
  - hsync = SYNC_POL when the H FSM is in H_SYN (hcount 840..967); otherwise ~SYNC_POL.
  - vsync = SYNC_POL when the V FSM is in V_SYN (vcount 601..604); otherwise ~SYNC_POL.
- active, line_start and frame_start are derived from the same registered (h,v). All outputs therefore describe the same pixel; there is no skew between sync and counters.
- x_c and y_c use two's-complement 12-bit arithmetic. x_c spans −400..655 and y_c spans −300..327. There is no saturation.
- Between ticks, every output holds its value.

## Timing
- Reset values:
  - pix_en=0, hcount=0, vcount=0.
  - hsync=vsync=~SYNC_POL.
  - active=line_start=frame_start=0.
  - x_c=y_c=0, frame_cnt=0.
  - div=0, both FSMs in their ACT state.
- First tick after reset release: the edge on which div reaches DIV−1. For DIV=3 this is the 3rd rising edge.
- On the first tick, outputs show pixel (0,0): active=1, line_start=1, frame_start=1, x_c=−400, y_c=−300. pix_en is high for the following clock.
- pix_en period is DIV clocks, with a duty of 1 clock.
- Latency from the internal position to the outputs is one tick.
- Line length is 1056 ticks. Frame length is 663168 ticks, which is 1989504 clocks at DIV=3.
- Reset asserted mid-frame: all state clears immediately (asynchronous). After release, timing restarts at (0,0) exactly as from power-up, with no partial sync pulse.
- Simultaneous h wrap and v wrap: both counters return to 0 on the same tick, and frame_start appears on that tick.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined: frame_cnt increments by 1 on every tick that registers frame_start=1, except the first one after reset. frame_cnt wraps 0xFFFF→0x0000. The shader stage uses it as an animation timer.
- VGA_TIMING_FRAME_CNT_EN undefined: frame_cnt is tied to 0 and no counter logic is synthesised.

## Test plan
- Reset held, then released → all reset values hold. With DIV=3, the first pix_en follows the 3rd edge and shows hcount=0, vcount=0, active=1, frame_start=1, x_c=−400.
- Free-run one line → hsync=0 for exactly 128 consecutive ticks (hcount 840..967). active falls at hcount=800. line_start recurs every 1056 ticks.
- Free-run one frame → vsync=0 for exactly 4 lines (vcount 601..604). frame_start recurs every 1989504 clocks. vcount reaches 627, then returns to 0.
- Assert reset_n=0 at hcount=900, vcount=602 → hsync and vsync return to 1 asynchronously. After release, the next tick shows (0,0).
- DIV=1, SYNC_POL=1 → pix_en is constantly high after the first edge. hsync=1 only during hcount 840..967.
- Macro defined, three frames run → frame_cnt=3. With the macro undefined, frame_cnt stays 0.
